// File: rtl/udma_i2c_target_pkg.sv
// Shared types and constants for the uDMA I2C target engine.
package udma_i2c_target_pkg;

  localparam int BIT_CNT_W = 4;
  localparam logic [7:0] TX_UNDERRUN_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK,
    WAIT_STOP
  } state_t;

endpackage

// File: rtl/udma_i2c_target_sync.sv
// Pad synchronizers for SCL/SDA plus edge, START and STOP detection.
module udma_i2c_target_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_now;

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_now  = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_now & ~scl_prev;
  assign scl_fall = ~scl_now & scl_prev;
  assign start    = scl_now & scl_prev & sda_prev & ~sda_s;
  assign stop     = scl_now & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/udma_i2c_target.sv
// I2C target engine: address match, ACK/NACK, and byte transfer between
// the bus and RX/TX valid/ready streams. No clock stretching.
module udma_i2c_target
  import udma_i2c_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       cfg_en_i,
  input  logic [6:0] cfg_addr_i,
  input  logic [7:0] data_tx_i,
  input  logic       data_tx_valid_i,
  output logic       data_tx_ready_o,
  output logic [7:0] data_rx_o,
  output logic       data_rx_valid_o,
  input  logic       data_rx_ready_i,
  output logic       busy_o,
  output logic       rw_o,
  output logic       evt_stop_o,
  output logic       evt_ovf_o,
  output logic       evt_unf_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       scl_oe,
  output logic       sda_o,
  output logic       sda_oe
);

  logic scl_rise, scl_fall, start, stop, sda_s;

  udma_i2c_target_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .scl_i   (scl_i),
    .sda_i   (sda_i),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop),
    .sda_s   (sda_s)
  );

  state_t               state_reg, state_next;
  logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0]           shift_reg, shift_next;
  logic [6:0]           addr_reg, addr_next;
  logic                 sda_oe_reg, sda_oe_next;
  logic                 phase_reg, phase_next;
  logic                 ack_reg, ack_next;
  logic                 rw_reg, rw_next;
  logic                 busy_reg, busy_next;
  logic                 evt_stop_reg, evt_stop_next;
  logic                 evt_ovf_reg, evt_ovf_next;
  logic                 evt_unf_reg, evt_unf_next;
  logic [7:0]           rx_data_reg;
  logic                 rx_valid_reg;
  logic                 rx_load, tx_pop, tx_enter, rx_space;
  logic [7:0]           rx_byte, tx_byte;

  assign rx_byte  = {shift_reg[6:0], sda_s};
  assign tx_byte  = data_tx_valid_i ? data_tx_i : TX_UNDERRUN_BYTE;
  // A byte may land in the holding register while the consumer pops it.
  assign rx_space = ~rx_valid_reg | data_rx_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      addr_reg     <= '0;
      sda_oe_reg   <= 1'b0;
      phase_reg    <= 1'b0;
      ack_reg      <= 1'b0;
      rw_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      evt_stop_reg <= 1'b0;
      evt_ovf_reg  <= 1'b0;
      evt_unf_reg  <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      addr_reg     <= addr_next;
      sda_oe_reg   <= sda_oe_next;
      phase_reg    <= phase_next;
      ack_reg      <= ack_next;
      rw_reg       <= rw_next;
      busy_reg     <= busy_next;
      evt_stop_reg <= evt_stop_next;
      evt_ovf_reg  <= evt_ovf_next;
      evt_unf_reg  <= evt_unf_next;
      if (rx_load) begin
        rx_data_reg  <= rx_byte;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && data_rx_ready_i) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    addr_next     = addr_reg;
    sda_oe_next   = sda_oe_reg;
    phase_next    = phase_reg;
    ack_next      = ack_reg;
    rw_next       = rw_reg;
    busy_next     = busy_reg;
    evt_stop_next = 1'b0;
    evt_ovf_next  = 1'b0;
    evt_unf_next  = 1'b0;
    rx_load       = 1'b0;
    tx_pop        = 1'b0;
    tx_enter      = 1'b0;

    if (!cfg_en_i) begin
      state_next  = IDLE;
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
    end else if (start) begin
      state_next   = ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
      addr_next    = cfg_addr_i;
    end else if (stop) begin
      state_next    = IDLE;
      sda_oe_next   = 1'b0;
      busy_next     = 1'b0;
      evt_stop_next = busy_reg;
    end else begin
      // phase_reg marks the second half of a 9th-clock slot (ACK driven/sampled).
      unique case (state_reg)
        ADDR: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 4'd7) begin
              phase_next = 1'b0;
              if (shift_reg[6:0] == addr_reg) begin
                state_next = ADDR_ACK;
                rw_next    = sda_s;
                busy_next  = 1'b1;
              end else begin
                state_next = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_reg) begin
              phase_next  = 1'b1;
              sda_oe_next = 1'b1;
            end else if (rw_reg) begin
              tx_enter = 1'b1;
            end else begin
              state_next   = RX_DATA;
              bit_cnt_next = '0;
              sda_oe_next  = 1'b0;
            end
          end
        end
        RX_DATA: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 4'd7) begin
              state_next = RX_ACK;
              phase_next = 1'b0;
              if (rx_space) begin
                rx_load  = 1'b1;
                ack_next = 1'b1;
              end else begin
                evt_ovf_next = 1'b1;
                ack_next     = 1'b0;
              end
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            if (!phase_reg) begin
              phase_next  = 1'b1;
              sda_oe_next = ack_reg;
            end else begin
              state_next   = RX_DATA;
              bit_cnt_next = '0;
              sda_oe_next  = 1'b0;
            end
          end
        end
        TX_DATA: begin
          if (scl_fall) begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 4'd7) begin
              state_next  = TX_ACK;
              sda_oe_next = 1'b0;
              phase_next  = 1'b0;
            end else begin
              shift_next  = {shift_reg[6:0], 1'b1};
              sda_oe_next = ~shift_reg[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_next = WAIT_STOP;
            else       phase_next = 1'b1;
          end else if (scl_fall && phase_reg) begin
            tx_enter = 1'b1;
          end
        end
        default: ;
      endcase

      if (tx_enter) begin
        state_next   = TX_DATA;
        bit_cnt_next = '0;
        shift_next   = tx_byte;
        sda_oe_next  = ~tx_byte[7];
        tx_pop       = data_tx_valid_i;
        evt_unf_next = ~data_tx_valid_i;
      end
    end
  end

  assign data_tx_ready_o = tx_pop;
  assign data_rx_o       = rx_data_reg;
  assign data_rx_valid_o = rx_valid_reg;
  assign busy_o          = busy_reg;
  assign rw_o            = rw_reg;
  assign evt_stop_o      = evt_stop_reg & cfg_en_i;
  assign evt_ovf_o       = evt_ovf_reg & cfg_en_i;
  assign evt_unf_o       = evt_unf_reg & cfg_en_i;
  assign scl_o           = 1'b0;
  assign scl_oe          = 1'b0;
  assign sda_o           = 1'b0;
  assign sda_oe          = sda_oe_reg;

endmodule

// File: tb/tb_udma_i2c_target.sv
// Directed bench: a bus-master model drives SCL/SDA and checks the target's replies.
module tb_udma_i2c_target;
  import udma_i2c_target_pkg::*;

  localparam int Q = 20;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       cfg_en_i = 1'b0;
  logic [6:0] cfg_addr_i = 7'h50;
  logic [7:0] data_tx_i;
  logic       data_tx_valid_i;
  logic       data_tx_ready_o;
  logic [7:0] data_rx_o;
  logic       data_rx_valid_o;
  logic       data_rx_ready_i = 1'b1;
  logic       busy_o, rw_o, evt_stop_o, evt_ovf_o, evt_unf_o;
  logic       scl_i, sda_i, scl_o, scl_oe, sda_o, sda_oe;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;

  logic [7:0] tx_mem [0:7];
  int         tx_len = 0;
  int         pop_cnt = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_log [0:63];
  int         stop_cnt = 0, ovf_cnt = 0, unf_cnt = 0, oe_cnt = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  assign scl_i           = scl_m;
  assign sda_i           = sda_m & ~sda_oe;
  assign data_tx_i       = tx_mem[pop_cnt[2:0]];
  assign data_tx_valid_i = (pop_cnt < tx_len);

  udma_i2c_target dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .cfg_en_i       (cfg_en_i),
    .cfg_addr_i     (cfg_addr_i),
    .data_tx_i      (data_tx_i),
    .data_tx_valid_i(data_tx_valid_i),
    .data_tx_ready_o(data_tx_ready_o),
    .data_rx_o      (data_rx_o),
    .data_rx_valid_o(data_rx_valid_o),
    .data_rx_ready_i(data_rx_ready_i),
    .busy_o         (busy_o),
    .rw_o           (rw_o),
    .evt_stop_o     (evt_stop_o),
    .evt_ovf_o      (evt_ovf_o),
    .evt_unf_o      (evt_unf_o),
    .scl_i          (scl_i),
    .sda_i          (sda_i),
    .scl_o          (scl_o),
    .scl_oe         (scl_oe),
    .sda_o          (sda_o),
    .sda_oe         (sda_oe)
  );

  // Observe handshakes and event pulses at the active edge.
  always @(posedge clk_i) begin
    if (data_tx_ready_o) pop_cnt <= pop_cnt + 1;
    if (data_rx_valid_o && data_rx_ready_i) begin
      rx_log[rx_cnt[5:0]] <= data_rx_o;
      rx_cnt <= rx_cnt + 1;
    end
    if (evt_stop_o) stop_cnt <= stop_cnt + 1;
    if (evt_ovf_o)  ovf_cnt  <= ovf_cnt + 1;
    if (evt_unf_o)  unf_cnt  <= unf_cnt + 1;
    if (sda_oe)     oe_cnt   <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk_i);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1;
    repeat (Q/2) @(negedge clk_i);
    b = sda_i;
    repeat (Q/2) @(negedge clk_i);
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         s_stop, s_oe, s_rx, s_pop, s_unf, s_ovf;

    tx_mem[0] = 8'h5A; tx_mem[1] = 8'hC3; tx_mem[2] = 8'h96;
    for (int i = 3; i < 8; i++) tx_mem[i] = 8'h00;

    // Reset state
    repeat (4) @(negedge clk_i);
    check("reset_outputs", {sda_oe, busy_o, rw_o, data_rx_valid_o, data_tx_ready_o,
          evt_stop_o, evt_ovf_o, evt_unf_o, data_rx_o, scl_o, scl_oe, sda_o}, 32'h0);
    rstn_i = 1'b1; cfg_en_i = 1'b1;
    repeat (4) @(negedge clk_i);

    // Write 0x3C, 0x81 to address 0x50
    s_stop = stop_cnt;
    i2c_start();
    write_byte(8'hA0, ack); check("wr_addr_ack", ack, 1'b0);
    check("wr_rw", rw_o, 1'b0);
    write_byte(8'h3C, ack); check("wr_b0_ack", ack, 1'b0);
    write_byte(8'h81, ack); check("wr_b1_ack", ack, 1'b0);
    check("wr_busy", busy_o, 1'b1);
    i2c_stop();
    check("wr_rx_cnt", rx_cnt, 2);
    check("wr_rx0", rx_log[0], 8'h3C);
    check("wr_rx1", rx_log[1], 8'h81);
    check("wr_stop_evt", stop_cnt - s_stop, 1);
    check("wr_busy_after", busy_o, 1'b0);

    // Address mismatch
    s_stop = stop_cnt; s_oe = oe_cnt; s_rx = rx_cnt;
    i2c_start();
    write_byte(8'hA2, ack); check("nm_addr_nack", ack, 1'b1);
    check("nm_busy", busy_o, 1'b0);
    write_byte(8'h55, ack); check("nm_data_nack", ack, 1'b1);
    i2c_stop();
    check("nm_oe_never", oe_cnt - s_oe, 0);
    check("nm_rx_none", rx_cnt - s_rx, 0);
    check("nm_no_stop_evt", stop_cnt - s_stop, 0);

    // Master read of two bytes
    tx_len = 2;
    s_stop = stop_cnt; s_pop = pop_cnt; s_unf = unf_cnt;
    i2c_start();
    write_byte(8'hA1, ack); check("rd_addr_ack", ack, 1'b0);
    check("rd_rw", rw_o, 1'b1);
    read_byte(rd, 1'b0); check("rd_b0", rd, 8'h5A);
    read_byte(rd, 1'b1); check("rd_b1", rd, 8'hC3);
    check("rd_state_wait", dut.state_reg, WAIT_STOP);
    check("rd_sda_rel", sda_oe, 1'b0);
    check("rd_busy", busy_o, 1'b1);
    i2c_stop();
    check("rd_pops", pop_cnt - s_pop, 2);
    check("rd_no_unf", unf_cnt - s_unf, 0);
    check("rd_stop_evt", stop_cnt - s_stop, 1);
    check("rd_state_idle", dut.state_reg, IDLE);

    // Read with no TX byte available
    s_pop = pop_cnt; s_unf = unf_cnt;
    i2c_start();
    write_byte(8'hA1, ack); check("unf_addr_ack", ack, 1'b0);
    read_byte(rd, 1'b1); check("unf_byte", rd, 8'hFF);
    i2c_stop();
    check("unf_evt", unf_cnt - s_unf, 1);
    check("unf_no_pop", pop_cnt - s_pop, 0);

    // RX holding register full
    data_rx_ready_i = 1'b0;
    s_ovf = ovf_cnt;
    i2c_start();
    write_byte(8'hA0, ack); check("ovf_addr_ack", ack, 1'b0);
    write_byte(8'h11, ack); check("ovf_b0_ack", ack, 1'b0);
    check("ovf_valid", data_rx_valid_o, 1'b1);
    write_byte(8'h22, ack); check("ovf_b1_nack", ack, 1'b1);
    check("ovf_evt", ovf_cnt - s_ovf, 1);
    check("ovf_held", data_rx_o, 8'h11);
    i2c_stop();
    data_rx_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("ovf_popped", data_rx_valid_o, 1'b0);
    check("ovf_logged", rx_log[rx_cnt-1], 8'h11);

    // Repeated START: write then read
    tx_len = 3;
    i2c_start();
    write_byte(8'hA0, ack); check("rs_addr_w_ack", ack, 1'b0);
    write_byte(8'h77, ack); check("rs_b0_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'hA1, ack); check("rs_addr_r_ack", ack, 1'b0);
    check("rs_rw", rw_o, 1'b1);
    read_byte(rd, 1'b1); check("rs_rd", rd, 8'h96);
    i2c_stop();
    check("rs_rx", rx_log[rx_cnt-1], 8'h77);

    // Reset mid-byte with a full RX register
    data_rx_ready_i = 1'b0;
    s_stop = stop_cnt;
    i2c_start();
    write_byte(8'hA0, ack); check("mr_addr_ack", ack, 1'b0);
    write_byte(8'h42, ack); check("mr_b0_ack", ack, 1'b0);
    check("mr_valid_pre", data_rx_valid_o, 1'b1);
    for (int i = 0; i < 4; i++) put_bit(1'b0);
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("mr_outputs_in_reset", {sda_oe, busy_o, rw_o, data_rx_valid_o, data_tx_ready_o,
          evt_stop_o, evt_ovf_o, evt_unf_o, data_rx_o}, 32'h0);
    rstn_i = 1'b1;
    data_rx_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("mr_outputs_after", {sda_oe, busy_o, rw_o, data_rx_valid_o}, 32'h0);
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    get_bit(ack); check("mr_idle_nack", ack, 1'b1);
    i2c_stop();
    check("mr_no_stop_evt", stop_cnt - s_stop, 0);
    check("mr_busy", busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
